// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: command indices, R1 flags, tokens, OCR values and FSM states for the SD SPI responder
package sd_spi_pkg;
    localparam logic [5:0] CMD_GO_IDLE         = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND    = 6'd8;
    localparam logic [5:0] CMD_SET_BLOCKLEN    = 6'd16;
    localparam logic [5:0] CMD_READ_SINGLE     = 6'd17;
    localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
    localparam logic [5:0] CMD_APP             = 6'd55;
    localparam logic [5:0] CMD_READ_OCR        = 6'd58;

    localparam logic [7:0] R1_READY    = 8'h00;
    localparam logic [7:0] R1_IDLE     = 8'h01;
    localparam logic [7:0] R1_ILLEGAL  = 8'h04;
    localparam logic [7:0] R1_ADDR_ERR = 8'h20;

    localparam logic [7:0] TOKEN_START = 8'hFE;
    localparam logic [7:0] TOKEN_IDLE  = 8'hFF;

    localparam logic [31:0] OCR_READY = 32'hC0FF8000;
    localparam logic [31:0] OCR_BUSY  = 32'h40FF8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_RX,
        ST_NCR,
        ST_RESP,
        ST_RD_GAP,
        ST_RD_TOKEN,
        ST_RD_DATA,
        ST_RD_CRC
    } state_t;
endpackage

// File: rtl/sd_spi_responder_spi_slave_byte.sv
// spi_slave_byte: synchronised SPI mode-0 byte shifter; rx on SCLK rise, tx on SCLK fall
module spi_slave_byte
    import sd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       selected,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_byte
);
    logic [2:0] sclk_sy, cs_sy;
    logic [1:0] mosi_sy;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [2:0] bit_cnt;
    logic       load, rise, fall;

    assign rise     = sclk_sy[1] & ~sclk_sy[2];
    assign fall     = ~sclk_sy[1] & sclk_sy[2];
    assign selected = ~cs_sy[1];
    assign miso     = tx_shift[7];
    assign tx_req   = rx_valid;

    // Deselect wins over any SCLK edge seen in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sy  <= '0;
            cs_sy    <= '1;
            mosi_sy  <= '1;
            rx_shift <= '0;
            tx_shift <= TOKEN_IDLE;
            bit_cnt  <= '0;
            load     <= 1'b0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            sclk_sy  <= {sclk_sy[1:0], sclk};
            cs_sy    <= {cs_sy[1:0], cs_n};
            mosi_sy  <= {mosi_sy[0], mosi};
            rx_valid <= 1'b0;
            if (!selected) begin
                bit_cnt  <= '0;
                load     <= 1'b0;
                tx_shift <= TOKEN_IDLE;
            end else if (rise) begin
                rx_shift <= {rx_shift[5:0], mosi_sy[1]};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_byte  <= {rx_shift, mosi_sy[1]};
                    rx_valid <= 1'b1;
                    load     <= 1'b1;
                end
            end else if (fall) begin
                tx_shift <= load ? tx_byte : {tx_shift[6:0], 1'b1};
                load     <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SDHC card model answering the init sequence and CMD17 block reads
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int BLOCKS_W   = 10,
    parameter int INIT_POLLS = 1
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                sd_spi_cs,
    input  logic                sd_spi_sclk,
    input  logic                sd_spi_mosi,
    output logic                sd_spi_miso,
    output logic [BLOCKS_W+8:0] mem_addr,
    output logic                mem_rd,
    input  logic [7:0]          mem_rdata,
    output logic                card_idle,
    output logic [5:0]          last_cmd
);
    state_t              state, state_d;
    logic                sel, rx_valid, tx_req;
    logic [7:0]          rx_byte, tx_byte;
    logic [5:0]          cmd_idx;
    logic [31:0]         arg;
    logic [8:0]          cnt;
    logic [39:0]         resp;
    logic                resp_rd, mem_rd_q, app;
    logic [BLOCKS_W-1:0] blk;
    logic [7:0]          poll_cnt;
    logic [7:0]          ex_r1;
    logic [31:0]         ex_data;
    logic [8:0]          ex_len;
    logic                ex_rd, acmd41, polling, blk_ok;

    spi_slave_byte u_spi (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .cs_n     (sd_spi_cs),
        .sclk     (sd_spi_sclk),
        .mosi     (sd_spi_mosi),
        .miso     (sd_spi_miso),
        .selected (sel),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .tx_byte  (tx_byte)
    );

    assign acmd41  = cmd_idx == CMD_SD_SEND_OP_COND && app;
    assign polling = int'(poll_cnt) < INIT_POLLS;
    assign blk_ok  = (arg >> BLOCKS_W) == 32'd0;

    // Response of the command whose CRC byte is completing; ex_len counts bytes after R1
    always_comb begin
        ex_r1   = R1_ILLEGAL | {7'd0, card_idle};
        ex_data = '1;
        ex_len  = 9'd0;
        ex_rd   = 1'b0;
        case (cmd_idx)
            CMD_GO_IDLE: ex_r1 = R1_IDLE;
            CMD_SEND_IF_COND: begin
                ex_r1   = {7'd0, card_idle};
                ex_data = {24'h000001, arg[7:0]};
                ex_len  = 9'd4;
            end
            CMD_APP: ex_r1 = {7'd0, card_idle};
            CMD_SD_SEND_OP_COND: if (app) ex_r1 = polling ? R1_IDLE : R1_READY;
            CMD_READ_OCR: begin
                ex_r1   = {7'd0, card_idle};
                ex_data = card_idle ? OCR_BUSY : OCR_READY;
                ex_len  = 9'd4;
            end
            CMD_READ_SINGLE: begin
                ex_r1 = card_idle ? (R1_ILLEGAL | R1_IDLE) : blk_ok ? R1_READY : R1_ADDR_ERR;
                ex_rd = !card_idle && blk_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= ST_IDLE;
        else state <= state_d;
    end

    // State names the slot being transmitted; transitions happen at byte boundaries
    always_comb begin
        state_d = state;
        if (!sel) state_d = ST_IDLE;
        else if (tx_req) begin
            case (state)
                ST_IDLE:     state_d = (rx_valid && rx_byte[7:6] == 2'b01) ? ST_CMD_RX : ST_IDLE;
                ST_CMD_RX:   state_d = cnt == 9'd4 ? ST_NCR : ST_CMD_RX;
                ST_NCR:      state_d = ST_RESP;
                ST_RESP:     state_d = cnt != 9'd0 ? ST_RESP : resp_rd ? ST_RD_GAP : ST_IDLE;
                ST_RD_GAP:   state_d = ST_RD_TOKEN;
                ST_RD_TOKEN: state_d = ST_RD_DATA;
                ST_RD_DATA:  state_d = cnt == 9'd511 ? ST_RD_CRC : ST_RD_DATA;
                ST_RD_CRC:   state_d = cnt == 9'd1 ? ST_IDLE : ST_RD_CRC;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_rd   = sel && tx_req && (state == ST_RD_TOKEN || (state == ST_RD_DATA && cnt != 9'd511));
        mem_addr = {blk, state == ST_RD_DATA ? cnt + 9'd1 : 9'd0};
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tx_byte   <= TOKEN_IDLE;
            cmd_idx   <= '0;
            arg       <= '0;
            cnt       <= '0;
            resp      <= '1;
            resp_rd   <= 1'b0;
            blk       <= '0;
            mem_rd_q  <= 1'b0;
            card_idle <= 1'b1;
            poll_cnt  <= '0;
            app       <= 1'b0;
            last_cmd  <= '0;
        end else begin
            mem_rd_q <= mem_rd;
            if (!sel) tx_byte <= TOKEN_IDLE;
            else if (mem_rd_q) tx_byte <= mem_rdata;
            else if (tx_req) begin
                tx_byte <= TOKEN_IDLE;
                cnt     <= cnt + 9'd1;
                case (state)
                    ST_IDLE: begin
                        cmd_idx <= rx_byte[5:0];
                        cnt     <= '0;
                    end
                    ST_CMD_RX: begin
                        if (cnt != 9'd4) arg <= {arg[23:0], rx_byte};
                        else begin
                            last_cmd <= cmd_idx;
                            resp     <= {ex_r1, ex_data};
                            resp_rd  <= ex_rd;
                            cnt      <= ex_len;
                            app      <= cmd_idx == CMD_APP;
                            if (ex_rd) blk <= arg[BLOCKS_W-1:0];
                            if (cmd_idx == CMD_GO_IDLE) begin
                                card_idle <= 1'b1;
                                poll_cnt  <= '0;
                            end else if (acmd41 && polling) poll_cnt <= poll_cnt + 8'd1;
                            else if (acmd41) card_idle <= 1'b0;
                        end
                    end
                    ST_NCR: begin
                        tx_byte <= resp[39:32];
                        resp    <= {resp[31:0], TOKEN_IDLE};
                        cnt     <= cnt;
                    end
                    ST_RESP: begin
                        if (cnt != 9'd0) begin
                            tx_byte <= resp[39:32];
                            resp    <= {resp[31:0], TOKEN_IDLE};
                            cnt     <= cnt - 9'd1;
                        end
                    end
                    ST_RD_GAP: begin
                        tx_byte <= TOKEN_START;
                        cnt     <= '0;
                    end
                    ST_RD_TOKEN: cnt <= '0;
                    default: ;
                endcase
            end
        end
    end
endmodule
